// File: rtl/cam_frame_tx.sv
// cam_frame_tx: synthetic imager that emits framed 40-bit LVDS-style words (sync code + 4 pixel lanes).
// The FSM and counters describe the word due next; the output register lags them by one edge.
module cam_frame_tx #(
   parameter int          LINE_WORDS  = 320,
   parameter int          LINES       = 1024,
   parameter int          HBLANK      = 16,
   parameter int          VBLANK      = 64,
   parameter logic [7:0]  SYNC_FS     = 8'hAA,
   parameter logic [7:0]  SYNC_LS     = 8'h2A,
   parameter logic [7:0]  SYNC_IMG    = 8'h35,
   parameter logic [7:0]  SYNC_LE     = 8'h0A,
   parameter logic [7:0]  SYNC_FE     = 8'hCA,
   parameter logic [7:0]  SYNC_BL     = 8'h15,
   parameter logic [7:0]  TRAIN       = 8'h3A,
   parameter bit          INVERT_DATA = 1'b0
) (
   input  logic        c,
   input  logic        rst_n,
   input  logic        en,
   input  logic [1:0]  pattern_sel,
   output logic [39:0] rxd,
   output logic        busy,
   output logic [15:0] frame_cnt
);
   localparam int WW = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
   localparam int RW = LINES > 1 ? $clog2(LINES) : 1;
   localparam int BW = $clog2((HBLANK > VBLANK ? HBLANK : VBLANK) + 1);
   localparam logic [WW-1:0] W_LAST = WW'(LINE_WORDS - 1);
   localparam logic [RW-1:0] R_LAST = RW'(LINES - 1);
   localparam logic [BW-1:0] H_LAST = BW'(HBLANK - 1);
   localparam logic [BW-1:0] V_LAST = BW'(VBLANK - 1);
   localparam logic [31:0] INV_MASK  = {32{INVERT_DATA}};
   localparam logic [31:0] IDLE_DATA = {4{TRAIN}} ^ INV_MASK;

   typedef enum logic [1:0] {IDLE, ACTIVE, HBL, VBL} state_t;

   state_t          r_state;
   logic [WW-1:0]   r_word;
   logic [RW-1:0]   r_row;
   logic [BW-1:0]   r_blank;
   logic [1:0]      r_pat;
   logic [7:0]      r_snap;
   logic            w_last_word;
   logic            w_last_row;
   logic            w_start;
   logic [7:0]      w_sync;
   logic [7:0]      w_col;
   logic [7:0]      w_row;
   logic [31:0]     w_data;

   assign w_last_word = r_word == W_LAST;
   assign w_last_row  = r_row == R_LAST;
   assign w_start     = en && (r_state == IDLE || (r_state == VBL && r_blank == V_LAST));
   assign w_sync      = r_word == '0 ? (r_row == '0 ? SYNC_FS : SYNC_LS) :
                        w_last_word  ? (w_last_row ? SYNC_FE : SYNC_LE) : SYNC_IMG;

   // Pixel values are taken mod 256, so column and row are folded to 8 bits up front.
   always_comb begin
      w_data = '0;
      w_col  = '0;
      w_row  = 8'(r_row);
      for (int i = 0; i < 4; i++) begin
         w_col = 8'({r_word, 2'(i)});
         w_data[8*i +: 8] = r_pat == 2'd0 ? w_col + w_row :
                            r_pat == 2'd1 ? {8{w_col[0] ^ w_row[0]}} :
                            r_pat == 2'd2 ? 8'h80 : r_snap;
      end
   end

   always_ff @(posedge c) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_word    <= '0;
         r_row     <= '0;
         r_blank   <= '0;
         r_pat     <= '0;
         r_snap    <= '0;
         rxd       <= {SYNC_BL, IDLE_DATA};
         busy      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         rxd  <= r_state == ACTIVE ? {w_sync, w_data ^ INV_MASK} : {SYNC_BL, IDLE_DATA};
         busy <= r_state != IDLE;
         if (r_state == ACTIVE && w_last_word && w_last_row)
            frame_cnt <= frame_cnt + 1'b1;
         if (w_start) begin
            r_pat  <= pattern_sel;
            r_snap <= frame_cnt[7:0];
         end
         case (r_state)
            IDLE: if (en) r_state <= ACTIVE;
            ACTIVE: begin
               if (w_last_word) begin
                  r_word  <= '0;
                  r_state <= w_last_row ? VBL : HBL;
                  if (w_last_row) r_row <= '0;
               end else begin
                  r_word <= r_word + 1'b1;
               end
            end
            HBL: begin
               if (r_blank == H_LAST) begin
                  r_blank <= '0;
                  r_row   <= r_row + 1'b1;
                  r_state <= ACTIVE;
               end else begin
                  r_blank <= r_blank + 1'b1;
               end
            end
            VBL: begin
               if (r_blank == V_LAST) begin
                  r_blank <= '0;
                  r_state <= en ? ACTIVE : IDLE;
               end else begin
                  r_blank <= r_blank + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cam_frame_tx.sv
// tb_cam_frame_tx: randomized self-checking bench for cam_frame_tx against a position-based frame model.
module tb_cam_frame_tx;
   localparam int LW = 4, NL = 3, HB = 2, VB = 5;
   localparam int LP = LW + HB;
   localparam int FL = NL * LP - HB + VB;
   localparam int FE_IDX = (NL - 1) * LP + LW - 1;
   localparam logic [39:0] IDLE_W = 40'h15_3A3A3A3A;

   logic        c = 1'b0, rst_n = 1'b0, en = 1'b0;
   logic [1:0]  ps = 2'd0;
   logic [39:0] rxd;
   logic        busy;
   logic [15:0] fc;
   logic        en_i = 1'b0;
   logic [1:0]  ps_i = 2'd2;
   logic [39:0] rxd_i;
   logic        busy_i;
   logic [15:0] fc_i;

   int          n_cmp = 0, n_err = 0;
   logic [15:0] m_fc = '0;
   logic [39:0] cap [FL];

   always #5 c = ~c;

   cam_frame_tx #(.LINE_WORDS(LW), .LINES(NL), .HBLANK(HB), .VBLANK(VB)) dut (
      .c(c), .rst_n(rst_n), .en(en), .pattern_sel(ps),
      .rxd(rxd), .busy(busy), .frame_cnt(fc));

   cam_frame_tx #(.LINE_WORDS(LW), .LINES(NL), .HBLANK(HB), .VBLANK(VB), .INVERT_DATA(1'b1)) dut_inv (
      .c(c), .rst_n(rst_n), .en(en_i), .pattern_sel(ps_i),
      .rxd(rxd_i), .busy(busy_i), .frame_cnt(fc_i));

   // Expected word at cycle idx of a frame, derived from line/blank geometry.
   function automatic logic [39:0] exp_word(int idx, logic [1:0] p, logic [7:0] snap);
      int r, o, col;
      logic [7:0]  s;
      logic [31:0] d;
      r = idx / LP;
      o = idx % LP;
      if (r >= NL || o >= LW) return IDLE_W;
      s = (o == 0) ? (r == 0 ? 8'hAA : 8'h2A) : (o == LW - 1) ? (r == NL - 1 ? 8'hCA : 8'h0A) : 8'h35;
      d = '0;
      for (int l = 0; l < 4; l++) begin
         col = 4 * o + l;
         case (p)
            2'd0: d[8*l +: 8] = 8'((col + r) % 256);
            2'd1: d[8*l +: 8] = ((col ^ r) & 1) != 0 ? 8'hFF : 8'h00;
            2'd2: d[8*l +: 8] = 8'h80;
            default: d[8*l +: 8] = snap;
         endcase
      end
      return {s, d};
   endfunction

   task automatic tick;
      @(posedge c);
      #1;
   endtask

   task automatic start(input logic [1:0] p);
      en = 1'b1;
      ps = p;
      tick;
      n_cmp++;
      if (rxd !== IDLE_W || busy !== 1'b0) begin
         n_err++;
         $display("FAIL start_latency: rxd=%h busy=%b expected rxd=%h busy=0", rxd, busy, IDLE_W);
      end
   endtask

   task automatic run_frame(input logic [1:0] p, input logic [1:0] np, input bit cont);
      logic [7:0]  snap;
      logic [39:0] e;
      snap = m_fc[7:0];
      for (int k = 0; k < FL; k++) begin
         if (k == FL - 1) begin
            en = cont;
            ps = np;
         end else begin
            en = 1'($urandom);
            ps = 2'($urandom);
         end
         tick;
         if (k == FE_IDX) m_fc++;
         e = exp_word(k, p, snap);
         cap[k] = rxd;
         n_cmp++;
         if (rxd !== e || busy !== 1'b1) begin
            n_err++;
            $display("FAIL frame_word[%0d] pat=%0d: rxd=%h busy=%b expected rxd=%h busy=1", k, p, rxd, busy, e);
         end
         if (k == FE_IDX) begin
            n_cmp++;
            if (fc !== m_fc) begin
               n_err++;
               $display("FAIL frame_cnt_at_fe: got %0d expected %0d", fc, m_fc);
            end
         end
      end
      if (!cont) begin
         en = 1'b0;
         tick;
         n_cmp++;
         if (rxd !== IDLE_W || busy !== 1'b0) begin
            n_err++;
            $display("FAIL frame_end_idle: rxd=%h busy=%b expected rxd=%h busy=0", rxd, busy, IDLE_W);
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      en = 1'b1;
      repeat (3) tick;
      n_cmp += 4;
      if (rxd !== IDLE_W) begin n_err++; $display("FAIL reset_rxd: got %h expected %h", rxd, IDLE_W); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (fc !== 16'd0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d expected 0", fc); end
      if (rxd_i !== 40'h15_C5C5C5C5) begin n_err++; $display("FAIL reset_inv_idle: got %h expected 15c5c5c5c5", rxd_i); end
      en = 1'b0;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_single_frame;
      logic [7:0] seq [FL];
      seq = '{8'hAA, 8'h35, 8'h35, 8'h0A, 8'h15, 8'h15, 8'h2A, 8'h35, 8'h35, 8'h0A, 8'h15,
              8'h15, 8'h2A, 8'h35, 8'h35, 8'hCA, 8'h15, 8'h15, 8'h15, 8'h15, 8'h15};
      start(2'd0);
      run_frame(2'd0, 2'd0, 1'b0);
      for (int k = 0; k < FL; k++) begin
         n_cmp++;
         if (cap[k][39:32] !== seq[k]) begin
            n_err++;
            $display("FAIL sync_seq[%0d]: got %h expected %h", k, cap[k][39:32], seq[k]);
         end
      end
      n_cmp += 3;
      if (cap[LP][31:0] !== 32'h04030201) begin n_err++; $display("FAIL row1_word0: got %h expected 04030201", cap[LP][31:0]); end
      if (cap[FE_IDX][31:24] !== 8'h11) begin n_err++; $display("FAIL row2_word3_lane3: got %h expected 11", cap[FE_IDX][31:24]); end
      if (fc !== 16'd1) begin n_err++; $display("FAIL single_frame_cnt: got %0d expected 1", fc); end
   endtask

   task automatic test_back_to_back;
      logic [1:0] p, np;
      logic [15:0] fc0;
      fc0 = m_fc;
      p = 2'd3;
      start(p);
      for (int f = 0; f < 4; f++) begin
         np = (f == 1) ? 2'd3 : 2'($urandom);
         run_frame(p, np, f < 3);
         p = np;
      end
      n_cmp++;
      if (fc !== fc0 + 16'd4) begin
         n_err++;
         $display("FAIL continuous_frame_cnt: got %0d expected %0d", fc, fc0 + 16'd4);
      end
   endtask

   task automatic test_pattern_latch;
      start(2'd1);
      run_frame(2'd1, 2'd0, 1'b0);
      n_cmp += 2;
      if (cap[0][31:0] !== 32'hFF00FF00) begin n_err++; $display("FAIL checker_row0: got %h expected ff00ff00", cap[0][31:0]); end
      if (cap[LP][31:0] !== 32'h00FF00FF) begin n_err++; $display("FAIL checker_row1: got %h expected 00ff00ff", cap[LP][31:0]); end
   endtask

   task automatic test_mid_reset;
      logic [39:0] e;
      logic [7:0]  snap;
      snap = m_fc[7:0];
      start(2'd0);
      en = 1'b0;
      for (int k = 0; k < LP + 2; k++) begin
         ps = 2'($urandom);
         tick;
         e = exp_word(k, 2'd0, snap);
         n_cmp++;
         if (rxd !== e) begin
            n_err++;
            $display("FAIL pre_reset_word[%0d]: got %h expected %h", k, rxd, e);
         end
      end
      rst_n = 1'b0;
      en = 1'b1;
      tick;
      m_fc = '0;
      n_cmp++;
      if (rxd !== IDLE_W || busy !== 1'b0 || fc !== 16'd0) begin
         n_err++;
         $display("FAIL mid_reset: rxd=%h busy=%b fc=%0d expected rxd=%h busy=0 fc=0", rxd, busy, fc, IDLE_W);
      end
      rst_n = 1'b1;
      start(2'd2);
      run_frame(2'd2, 2'd0, 1'b0);
   endtask

   task automatic test_invert;
      en_i = 1'b1;
      ps_i = 2'd2;
      tick;
      en_i = 1'b0;
      ps_i = 2'd0;
      tick;
      n_cmp++;
      if (rxd_i !== 40'hAA_7F7F7F7F) begin n_err++; $display("FAIL inv_fs: got %h expected aa7f7f7f7f", rxd_i); end
      tick;
      n_cmp++;
      if (rxd_i !== 40'h35_7F7F7F7F) begin n_err++; $display("FAIL inv_img: got %h expected 357f7f7f7f", rxd_i); end
      repeat (FL) tick;
      n_cmp++;
      if (rxd_i !== 40'h15_C5C5C5C5 || fc_i !== 16'd1) begin
         n_err++;
         $display("FAIL inv_end: rxd=%h fc=%0d expected rxd=15c5c5c5c5 fc=1", rxd_i, fc_i);
      end
   endtask

   initial begin
      test_reset;
      test_single_frame;
      test_back_to_back;
      test_pattern_latch;
      test_mid_reset;
      test_invert;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
